seq_shifter: RTL and testbench

Parametrised multi-cycle shifter for the ALU datapath. It replaces the fixed 32-bit left-only sequential shifter with a configurable-width unit. The unit supports logical left, logical right, arithmetic right and rotate left. It processes one power-of-two shift stage per clock and exchanges operands and results with the ALU sequencer over valid/ready handshakes.

---
 rtl/seq_shifter_pkg.sv | 19 +
 rtl/seq_shifter_shift_stage.sv | 37 +++
 rtl/seq_shifter.sv | 114 +++++++++++
 tb/tb_seq_shifter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/seq_shifter_pkg.sv
// seq_shifter_pkg: shared types for the multi-cycle shifter.
//   mode_e  : shift operation (SLL, SRL, SRA, ROL), 2-bit encoding
//   state_e : top-level FSM states
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shifter_shift_stage.sv
// shift_stage: combinational single power-of-two shift stage.
//   data  : working value in
//   stage : stage index k, shift distance is 2^k
//   en    : apply the shift (captured shamt bit k), else pass through
//   mode  : SLL / SRL / SRA / ROL
//   q     : shifted value out
module shift_stage
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] stage,
  input  logic               en,
  input  mode_e              mode,
  output logic [WIDTH-1:0]   q
);

  // stage never exceeds SHAMT_W-1, so amt <= WIDTH/2 and WIDTH-amt stays in range
  int unsigned amt;

  always_comb begin
    amt = 32'd1 << stage;
    q   = data;
    if (en) begin
      unique case (mode)
        MODE_SLL: q = data << amt;
        MODE_SRL: q = data >> amt;
        MODE_SRA: q = $unsigned($signed(data) >>> amt);
        MODE_ROL: q = (data << amt) | (data >> (WIDTH - amt));
        default:  q = data;
      endcase
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter, one power-of-two stage per clock.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand handshake (a, shamt, mode)
//   out_valid/out_ready  : result handshake (out_data)
//   busy                 : high while an operation is in BUSY or DONE
// Optional build macro SEQ_SHIFTER_EARLY_EXIT_EN: leave BUSY as soon as no
// higher shamt bits remain; shamt=0 goes straight to DONE at accept.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam logic [SHAMT_W-1:0] LAST_STAGE = SHAMT_W'(SHAMT_W - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] shamt_q;
  mode_e              mode_q;
  logic [SHAMT_W-1:0] stage_q;
  logic [WIDTH-1:0]   stage_out;
  logic               last_stage;

  shift_stage #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_stage (
    .data  (work_q),
    .stage (stage_q),
    .en    (shamt_q[stage_q]),
    .mode  (mode_q),
    .q     (stage_out)
  );

`ifdef SEQ_SHIFTER_EARLY_EXIT_EN
  // done once the current stage is the last one or no set bits remain above it
  assign last_stage = (stage_q == LAST_STAGE) || (((shamt_q >> stage_q) >> 1) == '0);
`else
  assign last_stage = (stage_q == LAST_STAGE);
`endif

  // result is read straight from the working register; it is only
  // rewritten at accept and in BUSY, so it holds through DONE and IDLE
  assign out_data = work_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      work_q    <= '0;
      shamt_q   <= '0;
      mode_q    <= MODE_SLL;
      stage_q   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            work_q   <= a;
            shamt_q  <= shamt;
            mode_q   <= mode_e'(mode);
            stage_q  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef SEQ_SHIFTER_EARLY_EXIT_EN
            if (shamt == '0) begin
              state_q   <= ST_DONE;
              out_valid <= 1'b1;
            end else begin
              state_q   <= ST_BUSY;
            end
`else
            state_q  <= ST_BUSY;
`endif
          end
        end
        ST_BUSY: begin
          work_q  <= stage_out;
          stage_q <= stage_q + 1'b1;
          if (last_stage) begin
            state_q   <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q   <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed plus random checks of seq_shifter (WIDTH=32)
// against an arithmetic reference model. Honours SEQ_SHIFTER_EARLY_EXIT_EN
// for expected latency.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [4:0]  shamt = '0;
  logic [1:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  seq_shifter #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .shamt     (shamt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] av, input logic [4:0] sv, input logic [1:0] mv);
    logic [63:0] t;
    case (mv)
      2'd0: return av << sv;
      2'd1: return av >> sv;
      2'd2: begin t = {{32{av[31]}}, av}; t = t >> sv; return t[31:0]; end
      default: begin t = {av, av} << sv; return t[63:32]; end
    endcase
  endfunction

  // clock edges after the accepting edge until out_valid is seen
  function automatic int exp_lat(input logic [4:0] sv);
`ifdef SEQ_SHIFTER_EARLY_EXIT_EN
    int hb = 0;
    for (int i = 0; i < 5; i++) if (sv[i]) hb = i + 1;
    return hb;
`else
    return (sv == 0) ? 5 : 5;
`endif
  endfunction

  // one full operation; hold = cycles of backpressure in DONE, poke = pulse
  // in_valid with a different operand during backpressure
  task automatic do_op(input logic [31:0] av, input logic [4:0] sv, input logic [1:0] mv,
                       input int hold, input bit poke);
    logic [31:0] exp;
    int lat;
    exp = model(av, sv, mv);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; a = av; shamt = sv; mode = mv; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_lat(sv));
    chk("out_data", out_data, exp);
    chk("busy_done", busy, 1);
    chk("in_ready_done", in_ready, 0);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        in_valid = 1'b1; a = ~av; shamt = 5'd1; mode = 2'd0;
      end
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, exp);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_in_ready", in_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_data_kept", out_data, exp);
  endtask

  initial begin
    logic [31:0] ra;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // directed scenarios
    do_op(32'h0000_0001, 5'd31, 2'd0, 0, 0);
    do_op(32'h8000_0000, 5'd4,  2'd2, 0, 0);
    do_op(32'h8000_0000, 5'd4,  2'd1, 0, 0);
    do_op(32'h8000_0001, 5'd1,  2'd3, 0, 0);
    do_op(32'h1234_5678, 5'd16, 2'd3, 0, 0);
    do_op(32'hDEAD_BEEF, 5'd0,  2'd2, 0, 0);
    do_op(32'hDEAD_BEEF, 5'd2,  2'd0, 0, 0);
    chk("const_sra", model(32'h8000_0000, 5'd4, 2'd2), 32'hF800_0000);
    // backpressure with a competing request
    do_op(32'hCAFE_0123, 5'd7,  2'd3, 3, 1);

    // reset during BUSY at stage 2
    @(negedge clk);
    in_valid = 1'b1; a = 32'hFFFF_0000; shamt = 5'd31; mode = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'h0000_0001, 5'd3, 2'd0, 0, 0);

    // random operations
    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      if (i % 8 == 0) ra[31] = 1'b1;
      do_op(ra, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
